// File: rtl/gol_cell.sv
// Single Game-of-Life cell: one registered alive/dead bit advanced from the
// population count of its 8 neighbours using parameterised birth/survival masks.
module gol_cell #(
  parameter logic [8:0] BIRTH_MASK   = 9'b000001000,
  parameter logic [8:0] SURVIVE_MASK = 9'b000001100
) (
  input  logic       clk,
  input  logic       resetN,
  output logic       out,
  input  logic [7:0] neighbouringCells,
  input  logic       initialState,
  input  logic       enable,
  input  logic       load,
  output logic [3:0] liveNeighbours,
  output logic       changed
);

  logic       out_q;
  logic       out_d;
  logic       changed_q;
  logic       changed_d;
  logic [3:0] live_count;
  logic       next_gen;

  // Population count; at most 8, so 4 bits never overflow.
  always_comb begin
    live_count = 4'd0;
    for (int i = 0; i < 8; i++) begin
      live_count = live_count + {3'b000, neighbouringCells[i]};
    end
  end

  always_comb begin
    next_gen = out_q ? SURVIVE_MASK[live_count] : BIRTH_MASK[live_count];
  end

  // Load outranks stepping; with neither, the cell holds and changed clears.
  always_comb begin
    out_d     = out_q;
    changed_d = 1'b0;
    if (load) begin
      out_d     = initialState;
      changed_d = 1'b0;
    end else if (enable) begin
      out_d     = next_gen;
      changed_d = (next_gen != out_q);
    end
  end

  always_ff @(posedge clk) begin
    if (!resetN) begin
      out_q     <= initialState;
      changed_q <= 1'b0;
    end else begin
      out_q     <= out_d;
      changed_q <= changed_d;
    end
  end

  assign out            = out_q;
  assign changed        = changed_q;
  assign liveNeighbours = live_count;

endmodule

// File: tb/tb_gol_cell.sv
// Scoreboard bench for gol_cell: the driver pushes the expected post-edge state,
// a monitor samples just after each rising edge and compares.
module tb_gol_cell;

  logic       clk;
  logic       resetN;
  logic       out;
  logic [7:0] neighbouringCells;
  logic       initialState;
  logic       enable;
  logic       load;
  logic [3:0] liveNeighbours;
  logic       changed;

  typedef struct {
    logic       out;
    logic       changed;
    logic [3:0] live;
  } exp_t;

  exp_t exp_q[$];
  int   check_count = 0;
  int   error_count = 0;
  bit   model_out   = 1'b0;

  gol_cell dut (
    .clk              (clk),
    .resetN           (resetN),
    .out              (out),
    .neighbouringCells(neighbouringCells),
    .initialState     (initialState),
    .enable           (enable),
    .load             (load),
    .liveNeighbours   (liveNeighbours),
    .changed          (changed)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Standard B3/S23 life rule written directly from the neighbour count.
  function automatic bit life_rule(input bit alive, input int n);
    if (alive) return (n == 2) || (n == 3);
    return n == 3;
  endfunction

  function automatic int count_alive(input logic [7:0] cells);
    int n = 0;
    foreach (cells[i]) if (cells[i]) n++;
    return n;
  endfunction

  task automatic apply_stimulus(input bit rst_n, input bit init, input bit en,
                                input bit ld, input logic [7:0] cells);
    exp_t e;
    int   n;
    bit   nxt;
    @(negedge clk);
    resetN            = rst_n;
    initialState      = init;
    enable            = en;
    load              = ld;
    neighbouringCells = cells;
    n      = count_alive(cells);
    e.live = n[3:0];
    if (!rst_n || ld) begin
      model_out = init;
      e.changed = 1'b0;
    end else if (en) begin
      nxt       = life_rule(model_out, n);
      e.changed = (nxt != model_out);
      model_out = nxt;
    end else begin
      e.changed = 1'b0;
    end
    e.out = model_out;
    exp_q.push_back(e);
  endtask

  task automatic check_output(input string name, input logic [3:0] actual,
                              input logic [3:0] required);
    check_count++;
    if (actual !== required) begin
      error_count++;
      $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, actual, required, $time);
    end
  endtask

  // Monitor: every rising edge after a stimulus presents one result.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check_output("out", {3'b000, out}, {3'b000, e.out});
        check_output("changed", {3'b000, changed}, {3'b000, e.changed});
        check_output("liveNeighbours", liveNeighbours, e.live);
      end
    end
  end

  initial begin
    int wait_cycles;
    resetN = 1'b1; initialState = 1'b0; enable = 1'b0; load = 1'b0;
    neighbouringCells = 8'h00;

    // Reset loads initialState either way.
    apply_stimulus(0, 1, 0, 0, 8'h00);
    apply_stimulus(0, 0, 1, 0, 8'hFF);
    // Survival on 2, death on 1 and on 8.
    apply_stimulus(1, 1, 0, 1, 8'h00);
    apply_stimulus(1, 0, 1, 0, 8'b00000011);
    apply_stimulus(1, 0, 1, 0, 8'b00000010);
    apply_stimulus(1, 1, 0, 1, 8'h00);
    apply_stimulus(1, 0, 1, 0, 8'hFF);
    // Birth on 3, no birth on 2.
    apply_stimulus(1, 0, 1, 0, 8'b00010101);
    apply_stimulus(1, 0, 0, 1, 8'h00);
    apply_stimulus(1, 0, 1, 0, 8'b00000011);
    // Hold with enable low.
    for (int i = 0; i < 5; i++) apply_stimulus(1, 1, 0, 0, 8'b00010101);
    // Load beats enable.
    apply_stimulus(1, 1, 0, 1, 8'h00);
    apply_stimulus(1, 0, 1, 1, 8'b00000111);
    // Mid-run reset, then stepping resumes.
    apply_stimulus(1, 0, 1, 0, 8'b00000111);
    apply_stimulus(1, 0, 1, 0, 8'b00001111);
    apply_stimulus(0, 1, 1, 0, 8'h00);
    apply_stimulus(1, 0, 1, 0, 8'h00);

    // Randomised mix, weighted toward stepping.
    for (int i = 0; i < 400; i++) begin
      apply_stimulus(($urandom_range(0, 29) != 0), $urandom_range(0, 1),
                     ($urandom_range(0, 3) != 0), ($urandom_range(0, 9) == 0),
                     8'($urandom));
    end

    wait_cycles = 0;
    while (exp_q.size() > 0 && wait_cycles < 20) begin
      @(posedge clk);
      wait_cycles++;
    end
    #2;
    if (exp_q.size() > 0) begin
      check_count++;
      error_count++;
      $display("[TB] FAIL drain: %0d results pending, expected 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", check_count, error_count);
    $finish;
  end

endmodule
